// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches against a credit
// limit, buffers returned words with their PCs, and flushes on redirect.
// Responses already in flight at a redirect are counted and discarded.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_inst,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   credit_used;
  logic             issue;
  logic             rsp_ok;
  logic             push;
  logic             pop;

  // Handshake decode; a response with nothing outstanding is treated as noise.
  always_comb begin
    credit_used = {1'b0, count} + {1'b0, inflight};
    issue       = rst_n && !redirect && (credit_used < {1'b0, DEPTH_C});
    rsp_ok      = rst_n && imem_rvalid && (inflight != '0);
    push        = rsp_ok && (drop_cnt == '0) && !redirect;
    pop         = rst_n && (count != '0) && out_ready && !redirect;
  end

  // Output view; everything is forced idle while reset is asserted.
  always_comb begin
    imem_req  = issue;
    imem_addr = issue ? fetch_pc : 32'h0;
    out_valid = rst_n && (count != '0);
    out_pc    = out_valid ? pc_mem[rd_ptr] : 32'h0;
    out_inst  = out_valid ? inst_mem[rd_ptr] : NOP_INST;
    occupancy = rst_n ? count : '0;
  end

  // Control state: PCs, pointers, occupancy and outstanding-response tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      // Everything still outstanding after this edge belongs to the old path.
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - CNT_W'(rsp_ok);
      drop_cnt <= inflight - CNT_W'(rsp_ok);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      inflight <= inflight + CNT_W'(issue) - CNT_W'(rsp_ok);
      if (rsp_ok && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

  // The fetch credit limit must make a push into a full queue impossible.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (count == DEPTH_C)));
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue with an in-order memory model and a
// queue-based reference of what the decode stage must see.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .occupancy(occupancy)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        oq[$];      // outstanding fetches, oldest first
  ent_t        fq[$];      // instructions the decode stage should see
  logic [31:0] m_fetch_pc = RESET_PC;
  int          cyc = 0;
  int          last_due = 0;
  int          errors = 0;
  int          checks = 0;
  int          obs_pops = 0;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_inst, obs_occ;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check every output against the model, then
  // advance the model by the same edge the DUT sees.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input int lat, input bit spur);
    bit          rv_real;
    bit          e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_inst, e_occ;
    int          due;
    req_t        r;
    @(negedge clk);
    rst_n = rst; redirect = redir; redirect_pc = rpc; out_ready = rdy;
    rv_real = rst && (oq.size() > 0) && (oq[0].due <= cyc);
    if (rv_real) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(oq[0].addr);
    end else if (rst && (oq.size() == 0) && spur) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    e_req   = rst && !redir && ((oq.size() + fq.size()) < DEPTH);
    e_addr  = e_req ? m_fetch_pc : 32'h0;
    e_valid = rst && (fq.size() > 0);
    e_pc    = e_valid ? fq[0].pc : 32'h0;
    e_inst  = e_valid ? fq[0].inst : NOP_INST;
    e_occ   = rst ? 32'(fq.size()) : 32'h0;
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = out_valid;
    obs_pc = out_pc; obs_inst = out_inst; obs_occ = 32'(occupancy);
    chk("imem_req", 32'(obs_req), 32'(e_req));
    chk("imem_addr", obs_addr, e_addr);
    chk("out_valid", 32'(obs_valid), 32'(e_valid));
    chk("out_pc", obs_pc, e_pc);
    chk("out_inst", obs_inst, e_inst);
    chk("occupancy", obs_occ, e_occ);
    if (obs_valid && rdy && !redir) obs_pops++;
    @(posedge clk);
    if (!rst) begin
      oq.delete(); fq.delete();
      m_fetch_pc = RESET_PC; last_due = cyc;
    end else if (redir) begin
      if (rv_real) void'(oq.pop_front());
      for (int i = 0; i < oq.size(); i++) oq[i].stale = 1'b1;
      fq.delete();
      m_fetch_pc = rpc;
    end else begin
      if ((fq.size() > 0) && rdy) void'(fq.pop_front());
      if (rv_real) begin
        r = oq.pop_front();
        if (!r.stale) fq.push_back('{pc: r.addr, inst: mem_word(r.addr)});
      end
      if (e_req) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        oq.push_back('{addr: m_fetch_pc, due: due, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_first;
    int seen;

    // Reset hold and sequential start-up with latency-1 memory.
    step(0, 0, 0, 1, 1, 0);
    chk("rst_req", 32'(obs_req), 32'h0);
    chk("rst_valid", 32'(obs_valid), 32'h0);
    chk("rst_inst", obs_inst, NOP_INST);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    chk("start_addr0", obs_addr, 32'h0);
    step(1, 0, 0, 1, 1, 0);
    chk("start_addr1", obs_addr, 32'h4);
    chk("start_valid1", 32'(obs_valid), 32'h0);
    step(1, 0, 0, 1, 1, 0);
    chk("start_addr2", obs_addr, 32'h8);
    chk("start_valid2", 32'(obs_valid), 32'h1);
    chk("start_pc0", obs_pc, 32'h0);
    chk("start_inst0", obs_inst, mem_word(32'h0));
    step(1, 0, 0, 1, 1, 0);
    chk("start_pc1", obs_pc, 32'h4);
    step(1, 0, 0, 1, 1, 0);
    chk("start_pc2", obs_pc, 32'h8);

    // Stalled decode fills the queue, then drains without loss.
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 0);
    chk("stall_occ", obs_occ, 32'h4);
    chk("stall_req", 32'(obs_req), 32'h0);
    chk("stall_pc", obs_pc, 32'h0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 1, 0);

    // Latency-2 memory, redirect with two fetches in flight while a response
    // arrives and decode is ready.
    step(0, 0, 0, 1, 2, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 2, 0);
    step(1, 1, 32'h100, 1, 2, 0);
    chk("redir_valid_before", 32'(obs_valid), 32'h1);
    chk("redir_rvalid", 32'(imem_rvalid), 32'h1);
    step(1, 0, 0, 1, 2, 0);
    chk("post_redir_valid", 32'(obs_valid), 32'h0);
    chk("post_redir_inst", obs_inst, NOP_INST);
    chk("post_redir_addr", obs_addr, 32'h100);
    got_first = 1'b0; seen = 0;
    for (int i = 0; i < 12 && seen < 2; i++) begin
      step(1, 0, 0, 1, 2, 0);
      if (obs_valid) begin
        chk(seen == 0 ? "redir_first_pc" : "redir_second_pc", obs_pc,
            seen == 0 ? 32'h100 : 32'h104);
        seen++;
      end
    end
    chk("redir_seen_two", 32'(seen), 32'h2);

    // Back-to-back redirects: the later target wins.
    step(1, 1, 32'h200, 1, 3, 0);
    step(1, 1, 32'h300, 1, 3, 0);
    step(1, 0, 0, 1, 3, 0);
    chk("b2b_addr", obs_addr, 32'h300);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 3, 0);

    // Mid-run reset with three queued and one outstanding.
    step(0, 0, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 2, 0);
    chk("pre_reset_model_occ", 32'(fq.size()), 32'h3);
    chk("pre_reset_model_inflight", 32'(oq.size()), 32'h1);
    step(0, 0, 0, 1, 1, 0);
    chk("in_reset_occ", obs_occ, 32'h0);
    step(1, 0, 0, 1, 1, 0);
    chk("after_reset_occ", obs_occ, 32'h0);
    chk("after_reset_valid", 32'(obs_valid), 32'h0);
    chk("after_reset_addr", obs_addr, RESET_PC);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 0);

    // Random traffic: stalls, latency 1-3, stray responses, redirects, resets.
    obs_pops = 0;
    for (int i = 0; i < 400; i++) begin
      bit r_rst, r_redir;
      r_rst   = ($urandom_range(0, 99) != 0);
      r_redir = r_rst && ($urandom_range(0, 29) == 0);
      step(r_rst, r_redir, $urandom & 32'hFFFF_FFFC, bit'($urandom_range(0, 1)),
           int'($urandom_range(1, 3)), $urandom_range(0, 7) == 0);
    end
    chk("random_pops_ge_20", 32'(obs_pops >= 20), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries, power of two, minimum 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 imem_req  output  1  fetch request issued this cycle.
REQ-006 imem_addr  output  32  fetch address, valid when imem_req=1.
REQ-007 imem_rvalid  input  1  instruction response valid.
REQ-008 imem_rdata  input  32  instruction word returned.
REQ-009 redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address when redirect=1.
REQ-011 out_ready  input  1  decode stage accepts head entry (driven as !stall).
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_pc  output  32  PC of head entry.
REQ-014 out_inst  output  32  instruction of head entry.
REQ-015 occupancy  output  $clog2(DEPTH)+1  valid entries held.

Function
REQ-016 State: fetch_pc, resp_pc, circular FIFO of {pc, inst} with read/write pointers (wrap modulo DEPTH), count, inflight, drop_cnt.
REQ-017 Memory contract: exactly one imem_rvalid per accepted imem_req, in order, latency >= 1 cycle; no back-pressure on requests.
REQ-018 imem_req SHALL be 1 iff rst_n=1, redirect=0 and count+inflight < DEPTH; imem_addr SHALL equal fetch_pc; imem_addr SHALL read 0 when imem_req=0.
REQ-019 On issue: fetch_pc += 4 (mod 2^32), inflight += 1.
REQ-020 On imem_rvalid with drop_cnt=0 and redirect=0: push {resp_pc, imem_rdata}, resp_pc += 4.
REQ-021 On imem_rvalid with drop_cnt>0: discard, drop_cnt -= 1; every imem_rvalid decrements inflight.
REQ-022 imem_rvalid while inflight=0 SHALL be ignored, with no state change.
REQ-023 out_valid = (count != 0); out_pc/out_inst = head entry; when empty out_pc=0 and out_inst=32'h0000_0013 (NOP).
REQ-024 Pop when out_valid & out_ready & !redirect; push and pop in the same cycle leave count unchanged.
REQ-025 Credit rule (REQ-018) guarantees no push when full; push-on-full is an assertion failure.
REQ-026 Redirect cycle: imem_req=0; at the edge count<=0 and pointers<=0, with fetch_pc and resp_pc <= redirect_pc.
REQ-027 Redirect cycle: drop_cnt <= inflight - imem_rvalid (under the REQ-022 rule), inflight <= same value; any response arriving in the redirect cycle is discarded; no pop occurs.
REQ-028 Fetch resumes at redirect_pc in the cycle after redirect; back-to-back redirects: the last one wins, and drop_cnt accumulates per REQ-027.
REQ-029 occupancy = count; count never exceeds DEPTH; count+inflight never exceeds DEPTH.

Reset
REQ-030 While rst_n=0 at an edge: fetch_pc=resp_pc=RESET_PC; count, inflight, drop_cnt and pointers = 0.
REQ-031 During reset: imem_req=0, out_valid=0, out_pc=0, out_inst=32'h0000_0013, occupancy=0; imem_rvalid ignored.
REQ-032 Reset mid-operation SHALL discard all entries and outstanding responses; the memory model is reset together with this block.

Verification
REQ-033 Reset release, latency-1 memory, out_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; out_valid first high 2 cycles after release; out_pc 0x0,0x4,0x8 in order.
REQ-034 out_ready=0, DEPTH=4 -> imem_req drops when count+inflight=4; occupancy settles at 4; out_pc holds 0x0; raising out_ready resumes with no loss or duplicate.
REQ-035 Latency-2 memory, redirect_pc=0x100 with 2 in flight -> next 2 responses dropped; first out_pc after redirect is 0x100, then 0x104.
REQ-036 redirect, imem_rvalid and out_ready all high in one cycle -> no pop, response dropped; next cycle out_valid=0, out_inst=0x13, imem_addr=redirect_pc.
REQ-037 rst_n low for 1 cycle with occupancy=3 and inflight=1 -> next cycle occupancy=0, out_valid=0; after release first imem_addr=RESET_PC; the stale response is not delivered.
REQ-038 Run 20 instructions with random out_ready and random latency 1-3 -> out_pc strictly +4 sequential, pointer wrap exercised, no push-on-full assertion.
